// File: rtl/cc_fill_pkg.sv
// Shared types, constants and the wrap-order helper for the cache line-fill engine.
package cc_fill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2
    } fill_state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Critical-word-first lane: beats wrap around the line starting at the missed word.
    function automatic int unsigned wrap_lane(input int unsigned first,
                                              input int unsigned cnt,
                                              input int unsigned beats = 32'd8);
        return (first + cnt) & (beats - 32'd1);
    endfunction

endpackage

// File: rtl/cc_beat_assembler.sv
// Line register built from BEATS lanes; each accepted beat overwrites exactly one lane.
module cc_beat_assembler #(
    parameter int DATA_W = 64,
    parameter int BEATS  = 8,
    localparam int BSEL_W = $clog2(BEATS),
    localparam int LINE_W = DATA_W * BEATS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [BSEL_W-1:0] lane,
    input  logic [DATA_W-1:0] beat,
    output logic [LINE_W-1:0] line
);

    logic [DATA_W-1:0] lane_r [BEATS];

    for (genvar g = 0; g < BEATS; g++) begin : g_lane
        // Lane storage; no per-line clear since every lane is rewritten on a complete fill.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                lane_r[g] <= '0;
            end else if (we && (lane == BSEL_W'(g))) begin
                lane_r[g] <= beat;
            end else begin
                lane_r[g] <= lane_r[g];
            end
        end

        assign line[g*DATA_W +: DATA_W] = lane_r[g];
    end

endmodule

// File: rtl/cc_line_fill_unit.sv
// Line-fill engine: pops a miss, gathers wrap-ordered R beats, writes tag+line to SRAM.
// Optional critical-word forwarding is built when CC_FILL_CWF_FWD_EN is defined.
module cc_line_fill_unit
    import cc_fill_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int BEATS  = 8,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 9,
    localparam int BOFF_W = $clog2(DATA_W / 8),
    localparam int BSEL_W = $clog2(BEATS),
    localparam int TAG_W  = ADDR_W - IDX_W - BSEL_W - BOFF_W,
    localparam int LINE_W = DATA_W * BEATS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic [1:0]        mem_rresp_i,
    input  logic              mem_rlast_i,
    input  logic              mem_rvalid_i,
    output logic              mem_rready_o,
    input  logic              miss_addr_fifo_empty_i,
    input  logic [ADDR_W-1:0] miss_addr_fifo_rdata_i,
    output logic              miss_addr_fifo_rden_o,
    output logic              wren_o,
    output logic [IDX_W-1:0]  waddr_o,
    output logic [TAG_W:0]    wdata_tag_o,
    output logic [LINE_W-1:0] wdata_data_o,
    output logic              fill_done_o,
    output logic              fill_err_o,
    output logic              fwd_valid_o,
    output logic [DATA_W-1:0] fwd_data_o
);

    localparam logic [BSEL_W-1:0] CNT_LAST = BSEL_W'(BEATS - 1);

    fill_state_e       state_r;
    fill_state_e       state_n_s;
    logic [IDX_W-1:0]  idx_r;
    logic [TAG_W:0]    tag_r;
    logic [BSEL_W-1:0] first_r;
    logic [BSEL_W-1:0] cnt_r;
    logic              err_r;
    logic              wren_r;
    logic              done_r;
    logic              ferr_r;

    logic              rden_s;
    logic              hs_s;
    logic              last_s;
    logic              err_n_s;
    logic [BSEL_W-1:0] lane_s;

    // Next-state, handshake and per-beat error evaluation.
    always_comb begin
        state_n_s = state_r;
        rden_s    = 1'b0;
        hs_s      = (state_r == RECV) && mem_rvalid_i;
        last_s    = hs_s && ((cnt_r == CNT_LAST) || mem_rlast_i);
        err_n_s   = err_r
                  | (mem_rresp_i != RESP_OKAY)
                  | (mem_rlast_i != (cnt_r == CNT_LAST));
        lane_s    = BSEL_W'(wrap_lane(32'(first_r), 32'(cnt_r), 32'(BEATS)));
        case (state_r)
            IDLE: begin
                if (!miss_addr_fifo_empty_i) begin
                    rden_s    = 1'b1;
                    state_n_s = RECV;
                end else begin
                    state_n_s = IDLE;
                end
            end
            RECV: begin
                if (last_s) begin
                    state_n_s = WRITE;
                end else begin
                    state_n_s = RECV;
                end
            end
            WRITE:   state_n_s = IDLE;
            default: state_n_s = IDLE;
        endcase
    end

    // State, captured miss fields, beat counter, sticky error and write-cycle outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= '0;
            tag_r   <= '0;
            first_r <= '0;
            cnt_r   <= '0;
            err_r   <= 1'b0;
            wren_r  <= 1'b0;
            done_r  <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            if (rden_s) begin
                idx_r   <= miss_addr_fifo_rdata_i[BOFF_W+BSEL_W +: IDX_W];
                tag_r   <= {1'b1, miss_addr_fifo_rdata_i[ADDR_W-1 -: TAG_W]};
                first_r <= miss_addr_fifo_rdata_i[BOFF_W +: BSEL_W];
                cnt_r   <= '0;
                err_r   <= 1'b0;
            end else if (hs_s) begin
                cnt_r   <= cnt_r + BSEL_W'(1);
                err_r   <= err_n_s;
            end else begin
                cnt_r   <= cnt_r;
                err_r   <= err_r;
            end
            // These flops are high exactly during the WRITE cycle.
            wren_r <= last_s && !err_n_s;
            done_r <= last_s && !err_n_s;
            ferr_r <= last_s && err_n_s;
        end
    end

    cc_beat_assembler #(
        .DATA_W (DATA_W),
        .BEATS  (BEATS)
    ) u_asm (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (hs_s),
        .lane  (lane_s),
        .beat  (mem_rdata_i),
        .line  (wdata_data_o)
    );

    assign mem_rready_o          = (state_r == RECV);
    assign miss_addr_fifo_rden_o = rden_s;
    assign wren_o                = wren_r;
    assign fill_done_o           = done_r;
    assign fill_err_o            = ferr_r;
    assign waddr_o               = idx_r;
    assign wdata_tag_o           = tag_r;

`ifdef CC_FILL_CWF_FWD_EN
    logic              fwd_valid_r;
    logic [DATA_W-1:0] fwd_data_r;

    // Capture the critical (first) beat of each line for the hit path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_valid_r <= 1'b0;
            fwd_data_r  <= '0;
        end else begin
            fwd_valid_r <= hs_s && (cnt_r == '0);
            if (hs_s && (cnt_r == '0)) begin
                fwd_data_r <= mem_rdata_i;
            end else begin
                fwd_data_r <= fwd_data_r;
            end
        end
    end

    assign fwd_valid_o = fwd_valid_r;
    assign fwd_data_o  = fwd_data_r;
`else
    assign fwd_valid_o = 1'b0;
    assign fwd_data_o  = '0;
`endif

endmodule

// File: tb/tb_cc_line_fill_unit.sv
// Directed self-checking bench for cc_line_fill_unit (default parameters).
module tb_cc_line_fill_unit;

    localparam int DATA_W = 64;
    localparam int BEATS  = 8;
    localparam int LINE_W = 512;

    logic              clk;
    logic              rst_n;
    logic [63:0]       mem_rdata_i;
    logic [1:0]        mem_rresp_i;
    logic              mem_rlast_i;
    logic              mem_rvalid_i;
    logic              mem_rready_o;
    logic              miss_addr_fifo_empty_i;
    logic [31:0]       miss_addr_fifo_rdata_i;
    logic              miss_addr_fifo_rden_o;
    logic              wren_o;
    logic [8:0]        waddr_o;
    logic [17:0]       wdata_tag_o;
    logic [511:0]      wdata_data_o;
    logic              fill_done_o;
    logic              fill_err_o;
    logic              fwd_valid_o;
    logic [63:0]       fwd_data_o;

    int n_tests;
    int n_fail;
    int rden_pulses;

    cc_line_fill_unit dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .mem_rdata_i            (mem_rdata_i),
        .mem_rresp_i            (mem_rresp_i),
        .mem_rlast_i            (mem_rlast_i),
        .mem_rvalid_i           (mem_rvalid_i),
        .mem_rready_o           (mem_rready_o),
        .miss_addr_fifo_empty_i (miss_addr_fifo_empty_i),
        .miss_addr_fifo_rdata_i (miss_addr_fifo_rdata_i),
        .miss_addr_fifo_rden_o  (miss_addr_fifo_rden_o),
        .wren_o                 (wren_o),
        .waddr_o                (waddr_o),
        .wdata_tag_o            (wdata_tag_o),
        .wdata_data_o           (wdata_data_o),
        .fill_done_o            (fill_done_o),
        .fill_err_o             (fill_err_o),
        .fwd_valid_o            (fwd_valid_o),
        .fwd_data_o             (fwd_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (miss_addr_fifo_rden_o) rden_pulses <= rden_pulses + 1;
    end

    task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line: beat i lands in lane (first+i) mod 8.
    function automatic logic [LINE_W-1:0] exp_line(input int first, input logic [63:0] base);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int i = 0; i < BEATS; i++) l[((first + i) % BEATS) * DATA_W +: DATA_W] = base + 64'(i);
        return l;
    endfunction

    task automatic start_fill(input logic [31:0] addr);
        miss_addr_fifo_rdata_i = addr;
        miss_addr_fifo_empty_i = 1'b0;
        #1;
        check("rden_pulse", {511'd0, miss_addr_fifo_rden_o}, 512'd1);
        tick();
        miss_addr_fifo_empty_i = 1'b1;
        #1;
        check("rden_low_recv", {511'd0, miss_addr_fifo_rden_o}, 512'd0);
    endtask

    // Sends beats 0..stop-1 of an n-beat burst; rlast on beat n-1, bad rresp on beat 'bad'.
    task automatic send_beats(input int n, input int stop, input logic [63:0] base,
                              input int bad, input bit gap);
        for (int i = 0; i < stop; i++) begin
            int w;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = base + 64'(i);
            mem_rresp_i  = (i == bad) ? 2'b10 : 2'b00;
            mem_rlast_i  = (i == n - 1);
            w = 0;
            while (!mem_rready_o && w < 20) begin
                tick();
                w++;
            end
            if (w >= 20) check("rready_timeout", 512'd0, 512'd1);
            tick();
            if (i == 0) begin
`ifdef CC_FILL_CWF_FWD_EN
                check("fwd_valid", {511'd0, fwd_valid_o}, 512'd1);
                check("fwd_data", {448'd0, fwd_data_o}, {448'd0, base});
`else
                check("fwd_valid_off", {511'd0, fwd_valid_o}, 512'd0);
`endif
            end
            if (gap && i < stop - 1) begin
                mem_rvalid_i = 1'b0;
                #1;
                check("gap_rready", {511'd0, mem_rready_o}, 512'd1);
                check("gap_no_wren", {511'd0, wren_o}, 512'd0);
                tick();
            end
        end
        mem_rvalid_i = 1'b0;
        mem_rlast_i  = 1'b0;
        mem_rresp_i  = 2'b00;
    endtask

    task automatic check_write(input string tag, input logic [8:0] idx, input logic [17:0] tg,
                               input logic [LINE_W-1:0] line);
        check({tag, "_wren"}, {511'd0, wren_o}, 512'd1);
        check({tag, "_done"}, {511'd0, fill_done_o}, 512'd1);
        check({tag, "_err"}, {511'd0, fill_err_o}, 512'd0);
        check({tag, "_waddr"}, {503'd0, waddr_o}, {503'd0, idx});
        check({tag, "_tag"}, {494'd0, wdata_tag_o}, {494'd0, tg});
        check({tag, "_data"}, wdata_data_o, line);
        check({tag, "_rready_write"}, {511'd0, mem_rready_o}, 512'd0);
        tick();
        check({tag, "_wren_one_cycle"}, {511'd0, wren_o}, 512'd0);
        check({tag, "_done_one_cycle"}, {511'd0, fill_done_o}, 512'd0);
    endtask

    task automatic check_drop(input string tag);
        check({tag, "_wren"}, {511'd0, wren_o}, 512'd0);
        check({tag, "_fill_err"}, {511'd0, fill_err_o}, 512'd1);
        check({tag, "_done"}, {511'd0, fill_done_o}, 512'd0);
        check({tag, "_rready_write"}, {511'd0, mem_rready_o}, 512'd0);
        tick();
        check({tag, "_err_one_cycle"}, {511'd0, fill_err_o}, 512'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        rden_pulses = 0;
        rst_n = 1'b0;
        mem_rdata_i = 64'd0;
        mem_rresp_i = 2'b00;
        mem_rlast_i = 1'b0;
        mem_rvalid_i = 1'b0;
        miss_addr_fifo_empty_i = 1'b1;
        miss_addr_fifo_rdata_i = 32'd0;
        tick();
        tick();
        check("rst_wren", {511'd0, wren_o}, 512'd0);
        check("rst_rready", {511'd0, mem_rready_o}, 512'd0);
        check("rst_waddr", {503'd0, waddr_o}, 512'd0);
        check("rst_tag", {494'd0, wdata_tag_o}, 512'd0);
        check("rst_data", wdata_data_o, 512'd0);
        check("rst_fwd", {447'd0, fwd_valid_o, fwd_data_o}, 512'd0);
        rst_n = 1'b1;
        tick();
        rden_pulses = 0;
        check("idle_rready", {511'd0, mem_rready_o}, 512'd0);

        // Aligned fill, first=0, idx 0x041, tag 0
        start_fill(32'h0000_1040);
        send_beats(8, 8, 64'hA000_0000_0000_0000, -1, 1'b0);
        check_write("aligned", 9'h041, 18'h20000, exp_line(0, 64'hA000_0000_0000_0000));
        check("aligned_line_lane0", {448'd0, wdata_data_o[63:0]}, {448'd0, 64'hA000_0000_0000_0000});
        check("aligned_rden_once", 512'(rden_pulses), 512'd1);

        // Wrapped fill, first=5: lanes 5,6,7,0..4 hold D0..D7
        start_fill(32'h0000_1068);
        send_beats(8, 8, 64'hB000_0000_0000_0010, -1, 1'b0);
        check_write("wrapped", 9'h041, 18'h20000, exp_line(5, 64'hB000_0000_0000_0010));

        // Gapped rvalid, first=3, idx 0x0F9, tag 0x1BD5B
        start_fill(32'hDEAD_BE58);
        send_beats(8, 8, 64'hC000_0000_0000_0100, -1, 1'b1);
        check_write("gapped", 9'h0F9, 18'h3BD5B, exp_line(3, 64'hC000_0000_0000_0100));

        // Bad response on beat 3, then a normal fill of the next queued miss
        start_fill(32'h0000_1040);
        send_beats(8, 8, 64'hD000_0000_0000_0000, 3, 1'b0);
        check_drop("resp_err");
        start_fill(32'h0000_2080);
        send_beats(8, 8, 64'hE000_0000_0000_0000, -1, 1'b0);
        check_write("after_err", 9'h082, 18'h20000, exp_line(0, 64'hE000_0000_0000_0000));

        // Early rlast on the 5th beat terminates and drops the line
        start_fill(32'h0000_1040);
        send_beats(5, 5, 64'hF000_0000_0000_0000, -1, 1'b0);
        check_drop("early_rlast");
        check("early_idle_rready", {511'd0, mem_rready_o}, 512'd0);

        // Reset after 4 beats of a fill
        start_fill(32'h0000_1048);
        send_beats(8, 4, 64'h1111_0000_0000_0000, -1, 1'b0);
        rst_n = 1'b0;
        tick();
        check("midrst_rready", {511'd0, mem_rready_o}, 512'd0);
        check("midrst_waddr_tag", {494'd0, wdata_tag_o}, 512'd0);
        check("midrst_waddr", {503'd0, waddr_o}, 512'd0);
        check("midrst_data", wdata_data_o, 512'd0);
        check("midrst_flags", {508'd0, wren_o, fill_done_o, fill_err_o, fwd_valid_o}, 512'd0);
        rst_n = 1'b1;
        tick();
        start_fill(32'h0000_1068);
        send_beats(8, 8, 64'h2222_0000_0000_0000, -1, 1'b0);
        check_write("post_rst", 9'h041, 18'h20000, exp_line(5, 64'h2222_0000_0000_0000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
